// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter that shares the UART TX FIFO write port
// between NUM_REQ byte-stream producers, with forced release of stalled packets.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned IDLE_TIMEOUT = 1024
) (
    input  logic                           clk,
    input  logic                           n_rst,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   i_req_data,
    input  logic [NUM_REQ-1:0]             i_req_last,
    output logic [NUM_REQ-1:0]             o_req_ready,
    output logic                           o_fifo_wr_en,
    output logic [DATA_BITS-1:0]           o_fifo_data,
    input  logic                           i_fifo_full,
    output logic [NUM_REQ-1:0]             o_grant,
    output logic                           o_busy,
    output logic                           o_timeout
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   g_idx;
    logic [PTR_W-1:0]   sel_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic               sel_found;
    logic [CNT_W-1:0]   idle_cnt;
    logic               g_valid;
    logic               g_last;
    logic               xfer;
    logic               to_hit;

    // First valid requester searching upward from the round-robin pointer
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!sel_found && i_req_valid[PTR_W'((32'(ptr) + i) % NUM_REQ)]) begin
                sel_found = 1'b1;
                sel_idx   = PTR_W'((32'(ptr) + i) % NUM_REQ);
            end
        end
    end

    assign g_valid  = i_req_valid[g_idx];
    assign g_last   = i_req_last[g_idx];
    assign xfer     = (state == ST_GRANT) && g_valid && !i_fifo_full;
    assign next_ptr = (32'(g_idx) == NUM_REQ - 1) ? '0 : g_idx + PTR_W'(1);

    // Counter is one short of the limit and about to increment: release next cycle
    assign to_hit = (IDLE_TIMEOUT > 0) && (state == ST_GRANT) && !g_valid &&
                    (idle_cnt == CNT_W'(IDLE_TIMEOUT - 1));

    // Grant path to the FIFO write port; o_grant is zero when idle
    assign o_req_ready  = o_grant & {NUM_REQ{~i_fifo_full}};
    assign o_fifo_wr_en = xfer;
    assign o_fifo_data  = (state == ST_GRANT) ? i_req_data[32'(g_idx)*DATA_BITS +: DATA_BITS]
                                              : '0;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            g_idx     <= '0;
            idle_cnt  <= '0;
            o_grant   <= '0;
            o_busy    <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sel_found) begin
                        state    <= ST_GRANT;
                        g_idx    <= sel_idx;
                        o_grant  <= NUM_REQ'(1) << sel_idx;
                        o_busy   <= 1'b1;
                        idle_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (xfer) begin
                        idle_cnt <= '0;
                        if (g_last) begin
                            state   <= ST_IDLE;
                            o_grant <= '0;
                            o_busy  <= 1'b0;
                            ptr     <= next_ptr;
                        end
                    end else if (to_hit) begin
                        state     <= ST_IDLE;
                        o_grant   <= '0;
                        o_busy    <= 1'b0;
                        o_timeout <= 1'b1;
                        ptr       <= next_ptr;
                        idle_cnt  <= '0;
                    end else if (!g_valid && (idle_cnt != '1)) begin
                        // Backpressure (valid high, FIFO full) holds the counter
                        idle_cnt <= idle_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
